// File: rtl/dsi_pkg.sv
// Shared types and constants for the DSI lane feeder: FSM states, the buffered
// byte entry layout and the data value driven when the lane pulls from an empty buffer.
package dsi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_ACT,
        ST_SEND,
        ST_DRAIN
    } feeder_state_t;

    localparam logic [7:0] UNDERFLOW_FILL = 8'h00;

    typedef struct packed {
        logic       mode_lp;
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/dsi_sync_fifo.sv
// Single-clock FIFO with show-ahead head output; pointers carry one extra bit so
// full and empty are distinguished without a separate counter.
module dsi_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/dsi_lane_feeder.sv
// Buffers packet bytes from the packet builder and hands them to a DSI lane:
// start handshake, byte-by-byte pulls, finish request, then wait for the lane to go idle.
module dsi_lane_feeder
    import dsi_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int START_TIMEOUT = 64
) (
    input  logic                          clk_sys,
    input  logic                          rst_n,
    input  logic                          lines_enable,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    input  logic                          s_last,
    input  logic                          s_mode_lp,
    output logic                          s_ready,
    output logic                          lane_lines_enable,
    output logic                          lane_mode_lp,
    output logic                          lane_start_rqst,
    output logic                          lane_fin_rqst,
    output logic [7:0]                    lane_inp_data,
    input  logic                          lane_data_rqst,
    input  logic                          lane_active,
    output logic                          busy,
    output logic                          underflow,
    output logic                          timeout_err,
    input  logic                          clr_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int TW = $clog2(START_TIMEOUT + 2);

    feeder_state_t state;
    fifo_entry_t   wr_entry;
    fifo_entry_t   head;
    logic [TW-1:0] timer;
    logic          in_pkt;
    logic          pkt_mode;
    logic          drop;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          send_pop;
    logic          drop_pop;

    assign s_ready  = !full;
    assign push     = s_valid && s_ready;

    // Mode is taken from the first byte only and replicated into the whole packet.
    assign wr_entry = '{mode_lp: (in_pkt ? pkt_mode : s_mode_lp), last: s_last, data: s_data};

    assign send_pop = rst_n && (state == ST_SEND) && lane_data_rqst && !empty;
    assign drop_pop = (state == ST_IDLE) && drop && !empty;
    assign pop      = send_pop || drop_pop;

    assign lane_fin_rqst     = send_pop && head.last;
    assign lane_inp_data     = ((state == ST_SEND) && !empty) ? head.data : UNDERFLOW_FILL;
    assign lane_lines_enable = lines_enable;
    assign busy              = (state != ST_IDLE);

    dsi_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_sys),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            in_pkt   <= 1'b0;
            pkt_mode <= 1'b0;
        end else if (push) begin
            if (!in_pkt) pkt_mode <= s_mode_lp;
            in_pkt <= !s_last;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            lane_start_rqst <= 1'b0;
            lane_mode_lp    <= 1'b0;
            timer           <= '0;
            drop            <= 1'b0;
            underflow       <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            lane_start_rqst <= 1'b0;
            // Later set assignments in the case below override this clear.
            if (clr_err) begin
                underflow   <= 1'b0;
                timeout_err <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    // A timed-out packet is discarded here, one entry per cycle.
                    if (drop) begin
                        if (drop_pop && head.last) drop <= 1'b0;
                    end else if (lines_enable && !empty) begin
                        state           <= ST_START;
                        lane_start_rqst <= 1'b1;
                        lane_mode_lp    <= head.mode_lp;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT_ACT;
                    timer <= '0;
                end
                ST_WAIT_ACT: begin
                    if (lane_active) begin
                        state <= ST_SEND;
                    end else if (timer > TW'(START_TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        drop        <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (lane_data_rqst) begin
                        if (empty)          underflow <= 1'b1;
                        else if (head.last) state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!lane_active) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsi_lane_feeder.sv
// Directed bench for dsi_lane_feeder: bytes accepted by the buffer are queued as
// expectations and checked against what the lane receives on each pull.
module tb_dsi_lane_feeder;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic       lines_enable;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_mode_lp;
    logic       s_ready;
    logic       lane_lines_enable;
    logic       lane_mode_lp;
    logic       lane_start_rqst;
    logic       lane_fin_rqst;
    logic [7:0] lane_inp_data;
    logic       lane_data_rqst;
    logic       lane_active;
    logic       busy;
    logic       underflow;
    logic       timeout_err;
    logic       clr_err;
    logic [3:0] fifo_level;

    int n_chk  = 0;
    int n_fail = 0;
    logic [8:0] exp_q[$];

    always #5 clk_sys = ~clk_sys;

    dsi_lane_feeder #(.FIFO_DEPTH(8), .START_TIMEOUT(64)) dut (
        .clk_sys           (clk_sys),
        .rst_n             (rst_n),
        .lines_enable      (lines_enable),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_last            (s_last),
        .s_mode_lp         (s_mode_lp),
        .s_ready           (s_ready),
        .lane_lines_enable (lane_lines_enable),
        .lane_mode_lp      (lane_mode_lp),
        .lane_start_rqst   (lane_start_rqst),
        .lane_fin_rqst     (lane_fin_rqst),
        .lane_inp_data     (lane_inp_data),
        .lane_data_rqst    (lane_data_rqst),
        .lane_active       (lane_active),
        .busy              (busy),
        .underflow         (underflow),
        .timeout_err       (timeout_err),
        .clr_err           (clr_err),
        .fifo_level        (fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    // One cycle of optional push and optional lane pull.
    task automatic cyc(input logic wr, input logic [7:0] d, input logic l, input logic m, input logic rd);
        logic [8:0] e;
        s_valid = wr; s_data = d; s_last = l; s_mode_lp = m; lane_data_rqst = rd;
        #1;
        if (rd) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = 9'h000;
            chk("pull_data", 32'(lane_inp_data), 32'(e[7:0]));
            chk("pull_fin", 32'(lane_fin_rqst), 32'(e[8]));
        end
        if (wr && s_ready) exp_q.push_back({l, d});
        tick;
        s_valid = 1'b0; lane_data_rqst = 1'b0;
    endtask

    task automatic wait_start;
        int n = 0;
        while (lane_start_rqst !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk("start_pulse", 32'(lane_start_rqst), 32'd1);
    endtask

    task automatic begin_send(input logic mode);
        wait_start;
        chk("start_mode", 32'(lane_mode_lp), 32'(mode));
        chk("start_busy", 32'(busy), 32'd1);
        tick;
        chk("start_once", 32'(lane_start_rqst), 32'd0);
        lane_active = 1'b1;
        tick;
    endtask

    task automatic end_drain;
        chk("drain_busy", 32'(busy), 32'd1);
        lane_active = 1'b0;
        tick;
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; lines_enable = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
        s_mode_lp = 1'b0; lane_data_rqst = 1'b0; lane_active = 1'b0; clr_err = 1'b0;
        tick; tick;
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_start", 32'(lane_start_rqst), 32'd0);
        chk("rst_fin", 32'(lane_fin_rqst), 32'd0);
        chk("rst_mode", 32'(lane_mode_lp), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_uflow", 32'(underflow), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        chk("rst_data", 32'(lane_inp_data), 32'h00);
        rst_n = 1'b1;
        tick;

        // HS packet A1 B2 C3; mode bit on a later byte must not matter
        cyc(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
        chk("hs_level", 32'(fifo_level), 32'd3);
        chk("hs_gated", 32'(busy), 32'd0);
        chk("lane_en_fwd", 32'(lane_lines_enable), 32'd0);
        lines_enable = 1'b1;
        #1;
        chk("lane_en_fwd1", 32'(lane_lines_enable), 32'd1);
        begin_send(1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        // pulls outside SEND are ignored
        lane_data_rqst = 1'b1;
        tick;
        lane_data_rqst = 1'b0;
        chk("drain_no_uflow", 32'(underflow), 32'd0);
        end_drain;

        // LP single-byte packet
        lines_enable = 1'b0;
        cyc(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
        lines_enable = 1'b1;
        begin_send(1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end_drain;

        // Fill to full, overflow byte dropped, then two 4-byte packets back to back
        lines_enable = 1'b0;
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 8'h10 + 8'(i), (i == 3 || i == 7), 1'b0, 1'b0);
        chk("full_level", 32'(fifo_level), 32'd8);
        chk("full_ready", 32'(s_ready), 32'd0);
        cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        chk("full_ignore", 32'(fifo_level), 32'd8);
        lines_enable = 1'b1;
        begin_send(1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("pop_level", 32'(fifo_level), 32'd7);
        cyc(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
        chk("pushpop_level", 32'(fifo_level), 32'd7);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("drain_hold", 32'({lane_start_rqst, busy}), 32'b01);
        end
        end_drain;
        begin_send(1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end_drain;
        begin_send(1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end_drain;

        // Underflow: lane pulls past the buffered bytes
        lines_enable = 1'b0;
        cyc(1'b1, 8'h91, 1'b0, 1'b0, 1'b0);
        lines_enable = 1'b1;
        begin_send(1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("pre_uflow", 32'(underflow), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("uflow_set", 32'(underflow), 32'd1);
        tick; tick;
        chk("uflow_sticky", 32'(underflow), 32'd1);
        clr_err = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        clr_err = 1'b0;
        chk("uflow_set_wins", 32'(underflow), 32'd1);
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        chk("uflow_clr", 32'(underflow), 32'd0);
        cyc(1'b1, 8'h92, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end_drain;

        // Start timeout: first packet dropped, second (LP) goes out normally
        lines_enable = 1'b0;
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'hCC, 1'b1, 1'b1, 1'b0);
        lines_enable = 1'b1;
        wait_start;
        n = 0;
        while (timeout_err !== 1'b1 && n < 200) begin
            tick;
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'd67);
        chk("tmo_idle", 32'(busy), 32'd0);
        while (exp_q.size() > 0) begin
            if (exp_q.pop_front() >= 9'h100) break;
        end
        begin_send(1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end_drain;
        chk("tmo_sticky", 32'(timeout_err), 32'd1);
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        chk("tmo_clr", 32'(timeout_err), 32'd0);

        // Reset in the middle of a packet
        lines_enable = 1'b0;
        cyc(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h62, 1'b1, 1'b0, 1'b0);
        lines_enable = 1'b1;
        begin_send(1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        lane_data_rqst = 1'b1;
        #1;
        chk("mid_rst_fin", 32'(lane_fin_rqst), 32'd0);
        tick;
        lane_data_rqst = 1'b0;
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(s_ready), 32'd1);
        chk("mid_rst_data", 32'(lane_inp_data), 32'h00);
        rst_n = 1'b1;
        lane_active = 1'b0;
        exp_q.delete();
        tick; tick;
        chk("post_rst_idle", 32'({lane_start_rqst, busy}), 32'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
